// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: interval/slot codes used by the
// alarm FSM, the parameter store and the readback scanner, plus the readback
// state encoding and a slot-advance helper.
package alarm_pkg;

  localparam int SLOT_W = 2;

  typedef enum logic [SLOT_W-1:0] {
    ARM_DELAY    = 2'd0,
    DRIVER_DELAY = 2'd1,
    PASS_DELAY   = 2'd2,
    ALARM_ON     = 2'd3
  } interval_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    CAPTURE = 2'd2,
    DWELL   = 2'd3
  } readback_state_e;

  // Step to the following slot, falling back to the first slot after the last.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] slot,
                                                  input logic [SLOT_W-1:0] last_slot);
    logic [SLOT_W-1:0] result;
    if (slot == last_slot) result = ARM_DELAY;
    else                   result = slot + SLOT_W'(1);
    return result;
  endfunction

endpackage

// File: rtl/param_readback_dwell_counter.sv
// Dwell timer for the parameter readback scanner: loaded with the number of
// one-second ticks a value stays on display, counts ticks down, and flags the
// tick that ends the dwell.
module dwell_counter #(
  parameter int LOAD_VALUE = 2,
  parameter int CNT_W      = $clog2(LOAD_VALUE + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // Load wins over a simultaneous tick so the full dwell always starts fresh.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(LOAD_VALUE);
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = tick && (count == CNT_W'(1));

endmodule

// File: rtl/param_readback.sv
// Sequential readback of the alarm controller's time-parameter store. A rising
// edge on the review switch walks every slot, reading each through the shared
// store port and holding it on the display for a fixed number of 1 Hz ticks.
// Build option: PARAM_READBACK_CONTINUOUS_EN makes the scan loop forever
// (no done pulse) until abort or reset.
module param_readback
  import alarm_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int DWELL_SECONDS = 2,
  parameter int VALUE_W       = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               one_hz_enable,
  input  logic               rd_gnt,
  input  logic [VALUE_W-1:0] rd_data,
  output logic               rd_req,
  output logic [1:0]         rd_sel,
  output logic [1:0]         disp_slot,
  output logic [VALUE_W-1:0] disp_value,
  output logic               disp_valid,
  output logic               busy,
  output logic               done
);

  localparam int                CNT_W     = $clog2(DWELL_SECONDS + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  readback_state_e   state;
  readback_state_e   state_next;
  logic              start_q;
  logic              start_edge;
  logic [SLOT_W-1:0] slot;
  logic              dwell_load;
  logic              dwell_tick;
  logic              dwell_expire;

  assign start_edge = start & ~start_q;
  assign dwell_load = (state == CAPTURE);
  assign dwell_tick = one_hz_enable && (state == DWELL);

  dwell_counter #(
    .LOAD_VALUE (DWELL_SECONDS),
    .CNT_W      (CNT_W)
  ) u_dwell (
    .clock  (clock),
    .reset  (reset),
    .load   (dwell_load),
    .tick   (dwell_tick),
    .expire (dwell_expire)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; abort overrides everything, including a start edge.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_edge) state_next = REQUEST;
        REQUEST: if (rd_gnt) state_next = CAPTURE;
        CAPTURE: state_next = DWELL;
        DWELL: begin
          if (dwell_expire) begin
`ifdef PARAM_READBACK_CONTINUOUS_EN
            state_next = REQUEST;
`else
            if (slot == LAST_SLOT) state_next = IDLE;
            else                   state_next = REQUEST;
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs decoded purely from registered state so rd_req cannot glitch.
  always_comb begin
    rd_req = (state == REQUEST);
    rd_sel = slot;
    busy   = (state != IDLE);
  end

  // Slot pointer, display registers, edge detector and done pulse. start_q
  // resets high so a switch already on when reset releases is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q    <= 1'b1;
      slot       <= ARM_DELAY;
      disp_slot  <= '0;
      disp_value <= '0;
      disp_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      if (abort) begin
        disp_valid <= 1'b0;
        slot       <= ARM_DELAY;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) slot <= ARM_DELAY;
          end
          CAPTURE: begin
            disp_value <= rd_data;
            disp_slot  <= slot;
            disp_valid <= 1'b1;
          end
          DWELL: begin
            if (dwell_expire) begin
              slot <= next_slot(slot, LAST_SLOT);
`ifndef PARAM_READBACK_CONTINUOUS_EN
              if (slot == LAST_SLOT) begin
                done       <= 1'b1;
                disp_valid <= 1'b0;
              end
`endif
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_readback.sv
// Directed self-checking bench for param_readback. A small store model answers
// granted reads one cycle later; ticks, grants, start and abort are driven by
// hand and every expected value is written out explicitly.
// Honors PARAM_READBACK_CONTINUOUS_EN when the design is built with it.
module tb_param_readback;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic       one_hz_enable;
  logic       rd_gnt;
  logic [3:0] rd_data;
  logic       rd_req;
  logic [1:0] rd_sel;
  logic [1:0] disp_slot;
  logic [3:0] disp_value;
  logic       disp_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [3:0] store_mem [4] = '{4'd6, 4'd8, 4'd15, 4'd10};

  param_readback #(
    .NUM_SLOTS     (4),
    .DWELL_SECONDS (2),
    .VALUE_W       (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .one_hz_enable (one_hz_enable),
    .rd_gnt        (rd_gnt),
    .rd_data       (rd_data),
    .rd_req        (rd_req),
    .rd_sel        (rd_sel),
    .disp_slot     (disp_slot),
    .disp_value    (disp_value),
    .disp_valid    (disp_valid),
    .busy          (busy),
    .done          (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Store model: granted read returns data next cycle, otherwise zero.
  always @(posedge clock) begin
    if (rd_req && rd_gnt) rd_data <= store_mem[rd_sel];
    else                  rd_data <= 4'd0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic gnt);
    one_hz_enable = tick;
    rd_gnt        = gnt;
    @(posedge clock);
    #1;
    one_hz_enable = 1'b0;
  endtask

  // Entered with the DUT in REQUEST for slot_i; leaves it in REQUEST for the
  // next slot (or IDLE / wrapped REQUEST after the last slot).
  task automatic runSlot(input int slot_i, input int prev_slot, input int prev_value,
                         input int stall, input bit last);
    checkOutput("req_up", rd_req, 1);
    checkOutput("req_sel", rd_sel, slot_i);
    for (int i = 0; i < stall; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("stall_req", rd_req, 1);
      checkOutput("stall_sel", rd_sel, slot_i);
      checkOutput("stall_val", disp_value, prev_value);
      checkOutput("stall_slot", disp_slot, prev_slot);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("req_drop", rd_req, 0);
    checkOutput("busy_cap", busy, 1);
    if (prev_value >= 0) checkOutput("hold_val", disp_value, prev_value);
    applyStimulus(1'b1, 1'b1);
    checkOutput("disp_slot", disp_slot, slot_i);
    checkOutput("disp_value", disp_value, store_mem[slot_i]);
    checkOutput("disp_valid", disp_valid, 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("dwell_req", rd_req, 0);
    checkOutput("dwell_busy", busy, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("dwell_hold", rd_req, 0);
    applyStimulus(1'b1, 1'b1);
    if (!last) begin
      checkOutput("next_req", rd_req, 1);
      checkOutput("next_sel", rd_sel, slot_i + 1);
      checkOutput("next_hold", disp_value, store_mem[slot_i]);
      checkOutput("next_done", done, 0);
    end else begin
`ifdef PARAM_READBACK_CONTINUOUS_EN
      checkOutput("wrap_req", rd_req, 1);
      checkOutput("wrap_sel", rd_sel, 0);
      checkOutput("wrap_done", done, 0);
      checkOutput("wrap_valid", disp_valid, 1);
`else
      checkOutput("done_pulse", done, 1);
      checkOutput("end_valid", disp_valid, 0);
      checkOutput("end_busy", busy, 0);
      checkOutput("end_req", rd_req, 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("done_drop", done, 0);
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    one_hz_enable = 1'b0;
    rd_gnt = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_req", rd_req, 0);
    checkOutput("rst_sel", rd_sel, 0);
    checkOutput("rst_valid", disp_valid, 0);
    checkOutput("rst_value", disp_value, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    reset = 1'b0;

    // Switch already on at reset release is not an edge.
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkOutput("no_edge_busy", busy, 0);
    checkOutput("no_edge_req", rd_req, 0);

    // Full pass with a five-cycle grant stall on slot 1 and a stray start edge.
    start = 1'b0;
    applyStimulus(1'b0, 1'b1);
    start = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_valid", disp_valid, 0);
    runSlot(0, -1, -1, 0, 1'b0);
    start = 1'b0;
    runSlot(1, 0, 6, 5, 1'b0);
    start = 1'b1;
    runSlot(2, 1, 8, 0, 1'b0);
    runSlot(3, 2, 15, 0, 1'b1);
`ifdef PARAM_READBACK_CONTINUOUS_EN
    for (int p = 0; p < 2; p++) begin
      runSlot(0, 3, 10, 0, 1'b0);
      runSlot(1, 0, 6, 0, 1'b0);
      runSlot(2, 1, 8, 0, 1'b0);
      runSlot(3, 2, 15, 0, 1'b1);
    end
    abort = 1'b1;
    applyStimulus(1'b0, 1'b1);
    abort = 1'b0;
    checkOutput("cont_abort_busy", busy, 0);
    checkOutput("cont_abort_done", done, 0);
`endif

    // Abort during the slot 2 dwell.
    start = 1'b0;
    applyStimulus(1'b0, 1'b1);
    start = 1'b1;
    applyStimulus(1'b0, 1'b1);
    runSlot(0, -1, -1, 0, 1'b0);
    runSlot(1, 0, 6, 0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ab_disp", disp_value, 15);
    applyStimulus(1'b1, 1'b1);
    abort = 1'b1;
    applyStimulus(1'b0, 1'b1);
    abort = 1'b0;
    checkOutput("ab_busy", busy, 0);
    checkOutput("ab_valid", disp_valid, 0);
    checkOutput("ab_req", rd_req, 0);
    checkOutput("ab_done", done, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ab_done2", done, 0);

    // Abort and start edge together in IDLE: stays idle.
    start = 1'b0;
    applyStimulus(1'b0, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    applyStimulus(1'b0, 1'b1);
    abort = 1'b0;
    checkOutput("abst_busy", busy, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abst_busy2", busy, 0);
    checkOutput("abst_req", rd_req, 0);

    // Asynchronous reset while capturing slot 1.
    start = 1'b0;
    applyStimulus(1'b0, 1'b1);
    start = 1'b1;
    applyStimulus(1'b0, 1'b1);
    runSlot(0, -1, -1, 0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_req", rd_req, 0);
    checkOutput("arst_sel", rd_sel, 0);
    checkOutput("arst_slot", disp_slot, 0);
    checkOutput("arst_value", disp_value, 0);
    checkOutput("arst_valid", disp_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_readback.md
# param_readback

Sequential reader for the time-parameter store of the alarm controller. On a review request it fetches each of the four stored interval values in turn through the store's single read port and presents each one on the display path for a fixed dwell, so the driver can check the programmed delays without entering reprogram mode. It sits between the debounced review switch, the parameter store's read port (arbitrated against the alarm FSM via a grant), and the display driver's digit inputs.

## Interface
- NUM_SLOTS, 4, number of parameter slots scanned (slot index = store interval code 0..NUM_SLOTS-1)
- DWELL_SECONDS, 2, one_hz_enable ticks each value is shown; legal range 1..15
- VALUE_W, 4, width of a stored parameter value
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- start  input  1  debounced review switch; level, rising edge starts a pass
- abort  input  1  synchronous cancel, level
- one_hz_enable  input  1  one-cycle 1 Hz tick from timer
- rd_gnt  input  1  store port granted to this block this cycle
- rd_data  input  VALUE_W  store read data, valid the cycle after a granted request
- rd_req  output  1  read request, held until granted
- rd_sel  output  2  slot being read; stable while rd_req high
- disp_slot  output  2  slot of the value on display
- disp_value  output  VALUE_W  value on display
- disp_valid  output  1  display digits meaningful
- busy  output  1  pass in progress (state not IDLE)
- done  output  1  one-cycle pulse at end of a completed pass

## Operation
- States: IDLE, REQUEST, CAPTURE, DWELL.
- IDLE: rising edge of start (start & !start_q) -> REQUEST, slot=0. start high out of reset is not an edge.
- REQUEST: rd_req=1, rd_sel=slot. rd_gnt=1 -> CAPTURE; else stay, rd_sel unchanged.
- CAPTURE: rd_data sampled at end of cycle into disp_value; disp_slot=slot; disp_valid=1; dwell counter loaded with DWELL_SECONDS -> DWELL. Tick in CAPTURE ignored.
- DWELL: each one_hz_enable decrements counter; tick with counter==1: if slot<NUM_SLOTS-1, slot+1 -> REQUEST; else done=1 for one cycle, disp_valid=0 -> IDLE.
- disp_valid and disp_value hold through REQUEST/CAPTURE of the next slot (no blanking between slots).
- abort in any state -> IDLE next edge, disp_valid=0, rd_req=0, no done. abort beats start in the same cycle.
- start edges while busy are ignored.
- Counter width $clog2(DWELL_SECONDS+1); slot counter 2 bits, no wrap beyond NUM_SLOTS-1 except under the macro below.

## Timing
- Reset values: rd_req 0, rd_sel 0, disp_slot 0, disp_value 0, disp_valid 0, busy 0, done 0; state IDLE.
- rd_req asserts the cycle after the start edge is sampled.
- With rd_gnt high: disp_value updates 2 cycles after rd_req first asserts (grant cycle + store latency cycle).
- Each slot displayed for DWELL_SECONDS ticks; first tick may arrive 1 cycle after entering DWELL (partial first second accepted).
- rd_req is registered-state decode; never glitches; drops the cycle after grant.
- Reset mid-pass: immediate return to IDLE with reset values.

## Configuration
- PARAM_READBACK_CONTINUOUS_EN: defined -> after last slot's dwell, slot wraps to 0 and REQUEST continues; done never asserts; only abort or reset ends the scan. Undefined -> single pass, done pulse, return to IDLE.

## Structure
- alarm_pkg: interval/slot codes (ARM_DELAY=0, DRIVER_DELAY=1, PASS_DELAY=2, ALARM_ON=3) shared with the alarm FSM and parameter store; readback state encoding.
- One sub-module: dwell_counter (load, tick, expire) instantiated once.

## Test plan
- Store values {6,8,15,10}, rd_gnt tied 1, DWELL_SECONDS=2: start edge -> disp (slot,value) = (0,6),(1,8),(2,15),(3,10), each for 2 ticks, then done pulse, disp_valid 0, busy 0.
- rd_gnt held 0 for 5 cycles in slot 1: rd_req high, rd_sel=1 stable all 5 cycles, disp still (0,6); grant -> (1,8) 2 cycles later.
- abort during slot 2 dwell -> next cycle IDLE, disp_valid 0, no done; abort and start same cycle in IDLE -> stays IDLE.
- start held high through reset release -> no pass; second start edge while busy -> ignored, pass order unchanged.
- Async reset asserted mid-CAPTURE -> all outputs at reset values immediately.
- With PARAM_READBACK_CONTINUOUS_EN: after slot 3 dwell, rd_sel=0 re-requested, done stays 0 over 3 full passes.
